planet_span_sequencer: RTL and testbench

//  Synchronous scanline sequencer for the planet sprite. Tracks the VGA

---
 rtl/planet_span_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_planet_span_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/planet_span_sequencer.sv
// ---------------------------------------------------------------------------
// planet_span_sequencer
//
// Scanline sequencer for the planet sprite. Watches the VGA line counter,
// grows the per-line half-span (span += inc; inc -= DEC, saturating) once per
// scanline while the planet is being drawn, and publishes the horizontal
// bounds of the current row together with a registered per-pixel hit.
//
// Geometry (top row, centre column, initial half-span, initial increment) is
// offered over a single-slot valid/ready port. An accepted word sits in a
// shadow register and only becomes live on the next frame start, so a frame
// in flight is never disturbed.
//
// Ports
//   clk         pixel clock
//   resetn      asynchronous reset, active low
//   HCounter    horizontal pixel counter from VGA timing
//   VCounter    vertical line counter from VGA timing
//   cfg_valid   config word offered
//   cfg_ready   config slot free (no pending config)
//   cfg_top     new first row
//   cfg_center  new centre column
//   cfg_span0   new initial half-span
//   cfg_inc0    new initial increment
//   span_lo     left bound of current row (inclusive)
//   span_hi     right bound of current row (inclusive)
//   active      current line is a planet row
//   in_planet   pixel hit, one clk after HCounter
//   frame_done  one-clk pulse when the last row has been stepped past
// ---------------------------------------------------------------------------
module planet_span_sequencer #(
  parameter logic [9:0] TOP_DEF    = 10'd456,
  parameter int         ROWS       = 58,
  parameter logic [9:0] CENTER_DEF = 10'd464,
  parameter logic [9:0] SPAN0_DEF  = 10'd44,
  parameter logic [9:0] INC0_DEF   = 10'd33,
  parameter logic [9:0] DEC        = 10'd1,
  parameter logic [9:0] H_LIMIT    = 10'd1023
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] HCounter,
  input  logic [9:0] VCounter,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [9:0] cfg_top,
  input  logic [9:0] cfg_center,
  input  logic [9:0] cfg_span0,
  input  logic [9:0] cfg_inc0,
  output logic [9:0] span_lo,
  output logic [9:0] span_hi,
  output logic       active,
  output logic       in_planet,
  output logic       frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [9:0] top;
    logic [9:0] center;
    logic [9:0] span0;
    logic [9:0] inc0;
  } cfg_t;

  // live geometry, shadow slot and its occupancy flag
  cfg_t live_q, live_d;
  cfg_t shad_q, shad_d;
  cfg_t eff_cfg;
  logic pend_q, pend_d;

  logic [9:0]    vc_q;
  logic [1:0]    state_q, state_d;
  logic [9:0]    span_q, span_d;
  logic [9:0]    inc_q, inc_d;
  logic [RW-1:0] row_q, row_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          inpl_q, inpl_d;
  logic [9:0]    lo_q, lo_d;
  logic [9:0]    hi_q, hi_d;

  logic          line_tick, frame_tick, accept, start, bnd_upd;
  logic [10:0]   span_sum, hi_sum;

  always_comb begin
    line_tick  = (VCounter != vc_q);
    frame_tick = line_tick && (VCounter == 10'd0);
    accept     = cfg_valid && !pend_q;

    // On a frame start the pending word (if any) is what this frame uses,
    // including the top==0 match in the very same cycle.
    eff_cfg = (frame_tick && pend_q) ? shad_q : live_q;
    live_d  = eff_cfg;

    shad_d = accept ? cfg_t'{cfg_top, cfg_center, cfg_span0, cfg_inc0} : shad_q;
    // accept implies the slot was empty, so a word arriving on the frame
    // tick is held for the following frame rather than applied now.
    if (accept)          pend_d = 1'b1;
    else if (frame_tick) pend_d = 1'b0;
    else                 pend_d = pend_q;

    span_sum = {1'b0, span_q} + {1'b0, inc_q};

    state_d  = state_q;
    span_d   = span_q;
    inc_d    = inc_q;
    row_d    = row_q;
    active_d = active_q;
    done_d   = 1'b0;
    start    = 1'b0;
    bnd_upd  = 1'b0;

    if (frame_tick) begin
      // a frame start aborts whatever was in flight, silently
      state_d  = S_WAIT;
      active_d = 1'b0;
      start    = (eff_cfg.top == 10'd0);
    end else begin
      case (state_q)
        S_WAIT: begin
          // a top row missed (e.g. reset mid-frame) waits a whole frame
          if (line_tick && VCounter == eff_cfg.top) start = 1'b1;
        end
        S_DRAW: begin
          if (line_tick) begin
            span_d  = (span_sum > 11'd1023) ? 10'd1023 : span_sum[9:0];
            inc_d   = (inc_q >= DEC) ? (inc_q - DEC) : 10'd0;
            row_d   = row_q + 1'b1;
            bnd_upd = 1'b1;
            if (row_q == LAST_ROW) begin
              active_d = 1'b0;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_WAIT;
      endcase
    end

    if (start) begin
      span_d   = eff_cfg.span0;
      inc_d    = eff_cfg.inc0;
      row_d    = '0;
      active_d = 1'b1;
      state_d  = S_DRAW;
      bnd_upd  = 1'b1;
    end

    // Bounds track span_d so they land in the same clk as span itself.
    // They hold between frames; in_planet is gated by active anyway.
    hi_sum = {1'b0, eff_cfg.center} + {1'b0, span_d};
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (bnd_upd) begin
      lo_d = (span_d > eff_cfg.center) ? 10'd0 : (eff_cfg.center - span_d);
      hi_d = (hi_sum > {1'b0, H_LIMIT}) ? H_LIMIT : hi_sum[9:0];
    end

    inpl_d = active_q && (HCounter >= lo_q) && (HCounter <= hi_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vc_q     <= '0;
      state_q  <= S_WAIT;
      live_q   <= cfg_t'{TOP_DEF, CENTER_DEF, SPAN0_DEF, INC0_DEF};
      shad_q   <= '0;
      pend_q   <= 1'b0;
      span_q   <= '0;
      inc_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      inpl_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      vc_q     <= VCounter;
      state_q  <= state_d;
      live_q   <= live_d;
      shad_q   <= shad_d;
      pend_q   <= pend_d;
      span_q   <= span_d;
      inc_q    <= inc_d;
      row_q    <= row_d;
      active_q <= active_d;
      done_q   <= done_d;
      inpl_q   <= inpl_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign cfg_ready  = !pend_q;
  assign span_lo    = lo_q;
  assign span_hi    = hi_q;
  assign active     = active_q;
  assign in_planet  = inpl_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_planet_span_sequencer.sv
// Bench for planet_span_sequencer. Lines are driven two clocks each; the
// DUT only reacts to VCounter changes so a short line is enough.
module tb_planet_span_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] HCounter, VCounter;
  logic       cfg_valid, cfg_ready;
  logic [9:0] cfg_top, cfg_center, cfg_span0, cfg_inc0;
  logic [9:0] span_lo, span_hi;
  logic       active, in_planet, frame_done;

  planet_span_sequencer dut (
    .clk(clk), .resetn(resetn), .HCounter(HCounter), .VCounter(VCounter),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_top(cfg_top),
    .cfg_center(cfg_center), .cfg_span0(cfg_span0), .cfg_inc0(cfg_inc0),
    .span_lo(span_lo), .span_hi(span_hi), .active(active),
    .in_planet(in_planet), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam int F_LO = 0, F_HI = 1, F_ACT = 2, F_INP = 3, F_DONE = 4, F_RDY = 5;

  typedef struct {
    string      tag;
    int         due;
    int         fld;
    logic [9:0] val;
  } exp_t;

  typedef struct {
    int         v;
    logic       act;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       done;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   cur = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [9:0] get(input int f);
    case (f)
      F_LO:    return span_lo;
      F_HI:    return span_hi;
      F_ACT:   return {9'd0, active};
      F_INP:   return {9'd0, in_planet};
      F_DONE:  return {9'd0, frame_done};
      default: return {9'd0, cfg_ready};
    endcase
  endfunction

  task automatic cmp(input string tag, input int f, input logic [9:0] want);
    logic [9:0] got;
    got = get(f);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s (field %0d): got %0d, want %0d @cyc %0d", tag, f, got, want, cyc);
  endtask

  task automatic push(input string tag, input int lat, input int f, input logic [9:0] v);
    sb.push_back('{tag, cyc + lat, f, v});
  endtask

  task automatic check_due();
    exp_t rest[$];
    foreach (sb[i]) begin
      if (sb[i].due == cyc) cmp(sb[i].tag, sb[i].fld, sb[i].val);
      else rest.push_back(sb[i]);
    end
    sb = rest;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  // advance line by line (wrapping at 525) until VCounter == to
  task automatic goto(input int to);
    while (cur != to) begin
      cur = (cur == 524) ? 0 : cur + 1;
      VCounter = 10'(cur);
      clk1();
      clk1();
    end
  endtask

  task automatic offer(input int t, input int c, input int s, input int i);
    cfg_valid  = 1'b1;
    cfg_top    = 10'(t);
    cfg_center = 10'(c);
    cfg_span0  = 10'(s);
    cfg_inc0   = 10'(i);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{455, 1'b0, 10'd0,   10'd0,    1'b0};
    tbl[1]  = '{456, 1'b1, 10'd420, 10'd508,  1'b0};
    tbl[2]  = '{457, 1'b1, 10'd387, 10'd541,  1'b0};
    tbl[3]  = '{458, 1'b1, 10'd355, 10'd573,  1'b0};
    tbl[4]  = '{472, 1'b1, 10'd12,  10'd916,  1'b0};
    tbl[5]  = '{473, 1'b1, 10'd0,   10'd933,  1'b0};
    tbl[6]  = '{479, 1'b1, 10'd0,   10'd1014, 1'b0};
    tbl[7]  = '{480, 1'b1, 10'd0,   10'd1023, 1'b0};
    tbl[8]  = '{489, 1'b1, 10'd0,   10'd1023, 1'b0};
    tbl[9]  = '{513, 1'b1, 10'd0,   10'd1023, 1'b0};
    tbl[10] = '{514, 1'b0, 10'd0,   10'd1023, 1'b1};

    resetn = 1'b0; HCounter = '0; VCounter = '0;
    cfg_valid = 1'b0; cfg_top = '0; cfg_center = '0; cfg_span0 = '0; cfg_inc0 = '0;
    #3;
    cmp("rst_lo", F_LO, 0);   cmp("rst_hi", F_HI, 0);   cmp("rst_act", F_ACT, 0);
    cmp("rst_inp", F_INP, 0); cmp("rst_done", F_DONE, 0); cmp("rst_rdy", F_RDY, 1);
    @(posedge clk); #1;
    resetn = 1'b1;

    // frame 1: default geometry, table of per-line expectations
    for (int k = 0; k < 11; k++) begin
      goto(tbl[k].v - 1);
      cur = tbl[k].v;
      VCounter = 10'(cur);
      push($sformatf("line%0d_act", cur),  1, F_ACT,  {9'd0, tbl[k].act});
      push($sformatf("line%0d_lo", cur),   1, F_LO,   tbl[k].lo);
      push($sformatf("line%0d_hi", cur),   1, F_HI,   tbl[k].hi);
      push($sformatf("line%0d_done", cur), 1, F_DONE, {9'd0, tbl[k].done});
      clk1();
      push($sformatf("line%0d_done2", cur), 1, F_DONE, 10'd0);
      clk1();
    end

    // frame 2: HCounter sweep around line 456
    goto(454);
    cur = 455; VCounter = 10'd455; HCounter = 10'd460;
    clk1();
    push("l455_inp", 1, F_INP, 0);
    clk1();
    cur = 456; VCounter = 10'd456; HCounter = 10'd0;
    clk1();
    for (int h = 400; h <= 530; h++) begin
      HCounter = 10'(h);
      push($sformatf("sweep_h%0d", h), 1, F_INP, {9'd0, (h >= 420 && h <= 508)});
      clk1();
    end
    HCounter = 10'd0;
    goto(513);
    cur = 514; VCounter = 10'd514; HCounter = 10'd460;
    clk1();
    push("l514_inp", 1, F_INP, 0);
    clk1();
    HCounter = 10'd0;

    // frame 3: reset in the middle of drawing
    goto(480);
    cmp("pre_rst_act", F_ACT, 1);
    resetn = 1'b0;
    #1;
    cmp("midrst_lo", F_LO, 0);   cmp("midrst_hi", F_HI, 0);  cmp("midrst_act", F_ACT, 0);
    cmp("midrst_inp", F_INP, 0); cmp("midrst_rdy", F_RDY, 1);
    clk1(); clk1();
    resetn = 1'b1;
    goto(500);
    cmp("postrst_act500", F_ACT, 0);
    goto(456);
    cmp("postrst_act456", F_ACT, 1);
    cmp("postrst_lo456", F_LO, 420);
    cmp("postrst_hi456", F_HI, 508);

    // frame 4: config mid-frame, second offer rejected
    goto(200);
    offer(100, 320, 10, 0);
    cmp("cfg1_rdy_before", F_RDY, 1);
    clk1();
    cfg_valid = 1'b0;
    cmp("cfg1_rdy_after", F_RDY, 0);
    goto(300);
    offer(5, 600, 1, 1);
    clk1();
    cfg_valid = 1'b0;
    cmp("cfg2_rejected_rdy", F_RDY, 0);
    goto(456);
    cmp("cfg_frame_act", F_ACT, 1);
    cmp("cfg_frame_lo", F_LO, 420);
    cmp("cfg_frame_hi", F_HI, 508);
    goto(524);
    cur = 0; VCounter = 10'd0;
    clk1();
    cmp("apply_rdy", F_RDY, 1);
    clk1();
    goto(5);
    cmp("cfg2_ignored_act5", F_ACT, 0);
    goto(100);
    cmp("newcfg_act100", F_ACT, 1);
    cmp("newcfg_lo100", F_LO, 310);
    cmp("newcfg_hi100", F_HI, 330);
    goto(101);
    cmp("newcfg_lo101", F_LO, 310);
    cmp("newcfg_hi101", F_HI, 330);
    goto(157);
    cmp("newcfg_act157", F_ACT, 1);
    cur = 158; VCounter = 10'd158;
    clk1();
    cmp("newcfg_done158", F_DONE, 1);
    cmp("newcfg_act158", F_ACT, 0);
    clk1();
    cmp("newcfg_done158b", F_DONE, 0);

    // frame 5: offer on the frame-tick cycle is held a whole frame
    goto(524);
    cur = 0; VCounter = 10'd0;
    offer(50, 200, 20, 0);
    cmp("ftcfg_rdy_before", F_RDY, 1);
    clk1();
    cfg_valid = 1'b0;
    cmp("ftcfg_rdy_after", F_RDY, 0);
    clk1();
    goto(50);
    cmp("ftcfg_held_act50", F_ACT, 0);
    goto(100);
    cmp("ftcfg_old_act100", F_ACT, 1);
    cmp("ftcfg_old_lo100", F_LO, 310);
    goto(524);
    cur = 0; VCounter = 10'd0;
    clk1();
    cmp("ftcfg_apply_rdy", F_RDY, 1);
    clk1();
    goto(50);
    cmp("ftcfg_act50", F_ACT, 1);
    cmp("ftcfg_lo50", F_LO, 180);
    cmp("ftcfg_hi50", F_HI, 220);

    // frame 7: top==0 starts on the frame-tick cycle itself
    goto(60);
    offer(0, 100, 5, 0);
    clk1();
    cfg_valid = 1'b0;
    goto(524);
    cur = 0; VCounter = 10'd0;
    clk1();
    cmp("top0_act", F_ACT, 1);
    cmp("top0_lo", F_LO, 95);
    cmp("top0_hi", F_HI, 105);
    clk1();

    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s: expectation never came due (due %0d, now %0d)", sb[i].tag, sb[i].due, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
